video_frame_ctrl: RTL and testbench

//  Frame sequencer in front of stream_video_filter on the AXI4-Stream video path (tuser=SOF, tlast=EOL).

---
 rtl/video_filter_pkg.sv | 22 ++
 rtl/axis_skid_buffer.sv | 61 ++++++
 rtl/video_frame_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_video_frame_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_filter_pkg.sv
// Shared types for the video frame path: sequencer states, default widths, error codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_filter_pkg;

    localparam int VIDEO_DATA_W = 24;  // RGB888 pixel
    localparam int VIDEO_CNT_W  = 12;  // pixel/line counters and geometry config

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DROP     = 2'd2
    } vfc_state_e;

    // Error codes, also decoded by the filter status logic.
    typedef logic [1:0] err_code_t;
    localparam err_code_t ERR_NONE  = 2'd0;
    localparam err_code_t ERR_SHORT = 2'd1;
    localparam err_code_t ERR_LONG  = 2'd2;
    localparam err_code_t ERR_SOF   = 2'd3;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output register slice for an AXI-Stream style interface.
// Latency: 1 cycle from an accepted input beat to out_vld_o; full throughput.
// Backpressure: in_rdy_o is high whenever fewer than two entries are held.
// Ports: clk, reset (sync, active-low); in_dat_i/in_vld_i/in_rdy_o upstream;
//        out_dat_o/out_vld_o/out_rdy_i downstream.
module axis_skid_buffer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_dat_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    output logic [W-1:0] out_dat_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         push;
    logic         pop;

    assign in_rdy_o  = (cnt_q != 2'd2);
    assign out_vld_o = (cnt_q != 2'd0);
    // Storage is cleared on reset so the data outputs read zero afterwards.
    assign out_dat_o = mem_q[rd_ptr_q];

    assign push = in_vld_i & in_rdy_o;
    assign pop  = out_vld_o & out_rdy_i;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame sequencer: locks on SOF, checks line width / frame height, drops malformed data until next SOF.
// Latency: 1 cycle through a 2-entry skid buffer; full throughput.
// Backpressure: s_axis_video_tready follows skid-buffer space (forced low in reset); dropped beats still need space.
// Ports: s_axis_video_* slave in, m_axis_video_* master out to the filter, cfg_width/cfg_height/cfg_bypass
//        geometry and bypass request (applied at SOF), filter_bypass, and 1-cycle pulses frame_done/err_*.
// Optional: VIDEO_FRAME_CTRL_STATS_EN adds saturating frame_cnt, err_cnt and drop_cnt outputs.
module video_frame_ctrl
    import video_filter_pkg::*;
#(
    parameter int DATA_W = VIDEO_DATA_W,
    parameter int CNT_W  = VIDEO_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_video_tdata,
    input  logic              s_axis_video_tvalid,
    input  logic              s_axis_video_tuser,
    input  logic              s_axis_video_tlast,
    output logic              s_axis_video_tready,
    output logic [DATA_W-1:0] m_axis_video_tdata,
    output logic              m_axis_video_tvalid,
    output logic              m_axis_video_tuser,
    output logic              m_axis_video_tlast,
    input  logic              m_axis_video_tready,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_height,
    input  logic              cfg_bypass,
    output logic              filter_bypass,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic              err_sof
`ifdef VIDEO_FRAME_CTRL_STATS_EN
    ,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       err_cnt,
    output logic [31:0]       drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    vfc_state_e       state_q, state_d;
    logic [CNT_W-1:0] px_q, px_d;
    logic [CNT_W-1:0] ln_q, ln_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic             byp_q, byp_d;
    logic             done_q, done_d;
    err_code_t        err_q, err_d;

    logic             skid_rdy;
    logic             beat;
    logic             fwd;
    logic             force_last;
    logic [CNT_W-1:0] cfg_w_eff;
    logic [CNT_W-1:0] cfg_h_eff;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] lnv;
    logic [CNT_W-1:0] wv;
    logic [CNT_W-1:0] hv;

    assign s_axis_video_tready = reset & skid_rdy;
    assign beat = s_axis_video_tvalid & s_axis_video_tready;

    assign cfg_w_eff = (cfg_width  == '0) ? CNT_ONE : cfg_width;
    assign cfg_h_eff = (cfg_height == '0) ? CNT_ONE : cfg_height;

    // An SOF beat is evaluated as pixel 0 of line 0 against the freshly
    // latched geometry, so W=1 and mid-frame SOFs share the normal checks.
    assign pos = s_axis_video_tuser ? '0 : px_q;
    assign lnv = s_axis_video_tuser ? '0 : ln_q;
    assign wv  = s_axis_video_tuser ? cfg_w_eff : w_q;
    assign hv  = s_axis_video_tuser ? cfg_h_eff : h_q;

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        ln_d       = ln_q;
        w_d        = w_q;
        h_d        = h_q;
        byp_d      = byp_q;
        done_d     = 1'b0;
        err_d      = ERR_NONE;
        fwd        = 1'b0;
        force_last = 1'b0;
        if (beat && (state_q == ACTIVE || s_axis_video_tuser)) begin
            fwd = 1'b1;
            if (s_axis_video_tuser) begin
                w_d   = cfg_w_eff;
                h_d   = cfg_h_eff;
                byp_d = cfg_bypass;
            end
            if (pos == wv - CNT_ONE) begin
                if (s_axis_video_tlast) begin
                    px_d = '0;
                    if (lnv == hv - CNT_ONE) begin
                        done_d  = 1'b1;
                        ln_d    = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        ln_d    = lnv + CNT_ONE;
                        state_d = ACTIVE;
                    end
                end else begin
                    // Close the line downstream so the filter stays aligned.
                    force_last = 1'b1;
                    err_d      = ERR_LONG;
                    px_d       = '0;
                    ln_d       = '0;
                    state_d    = DROP;
                end
            end else if (s_axis_video_tlast) begin
                err_d   = ERR_SHORT;
                px_d    = '0;
                ln_d    = '0;
                state_d = DROP;
            end else begin
                px_d    = pos + CNT_ONE;
                ln_d    = lnv;
                state_d = ACTIVE;
            end
            // Restarted frame is reported as an SOF error only.
            if (s_axis_video_tuser && state_q == ACTIVE) begin
                err_d = ERR_SOF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT_SOF;
            px_q    <= '0;
            ln_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            byp_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            ln_q    <= ln_d;
            w_q     <= w_d;
            h_q     <= h_d;
            byp_q   <= byp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign filter_bypass = byp_q;
    assign frame_done    = done_q;
    assign err_short     = (err_q == ERR_SHORT);
    assign err_long      = (err_q == ERR_LONG);
    assign err_sof       = (err_q == ERR_SOF);

    axis_skid_buffer #(
        .W (DATA_W + 2)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_dat_i  ({s_axis_video_tdata, s_axis_video_tuser, s_axis_video_tlast | force_last}),
        .in_vld_i  (beat & fwd),
        .in_rdy_o  (skid_rdy),
        .out_dat_o ({m_axis_video_tdata, m_axis_video_tuser, m_axis_video_tlast}),
        .out_vld_o (m_axis_video_tvalid),
        .out_rdy_i (m_axis_video_tready)
    );

`ifdef VIDEO_FRAME_CTRL_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] err_cnt_q;
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (done_d && frame_cnt_q != '1) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            // At most one error code per beat, so a unit step sums all pulses.
            if (err_d != ERR_NONE && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (beat && !fwd && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_video_frame_ctrl.sv
// Scoreboard bench for video_frame_ctrl: directed frames push expected output beats,
// a separate monitor pops and compares whenever the DUT presents a beat.
module tb_video_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tuser;
    logic        s_tlast;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tready;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic        cfg_bypass;
    logic        filter_bypass;
    logic        frame_done;
    logic        err_short;
    logic        err_long;
    logic        err_sof;
`ifdef VIDEO_FRAME_CTRL_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [31:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    video_frame_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tready (s_tready),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tready (m_tready),
        .cfg_width           (cfg_width),
        .cfg_height          (cfg_height),
        .cfg_bypass          (cfg_bypass),
        .filter_bypass       (filter_bypass),
        .frame_done          (frame_done),
        .err_short           (err_short),
        .err_long            (err_long),
        .err_sof             (err_sof)
`ifdef VIDEO_FRAME_CTRL_STATS_EN
        ,
        .frame_cnt           (frame_cnt),
        .err_cnt             (err_cnt),
        .drop_cnt            (drop_cnt)
`endif
    );

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
        logic        fd;
        logic        es;
        logic        el;
        logic        esof;
        logic        byp;
    } rec_t;

    rec_t exp_q[$];
    int   cyc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   chk_pulses = 1'b1;
    bit   bp_en = 1'b0;
    int   cnt_fd = 0, cnt_es = 0, cnt_el = 0, cnt_esof = 0;
    int   last_wait = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dat(input int f, input int ln, input int px);
        return {8'(f), 8'(ln), 8'(px)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops and compares on every presented output beat.
    initial begin
        rec_t        e;
        rec_t        act;
        int          ec;
        bit          prev_stall;
        logic [25:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                cnt_fd   += int'(frame_done);
                cnt_es   += int'(err_short);
                cnt_el   += int'(err_long);
                cnt_esof += int'(err_sof);
                if (prev_stall) check("hold_stable", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, prev_dat});
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got data %h user %b last %b, expected no beat", m_tdata, m_tuser, m_tlast);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        act = '{d: m_tdata, u: m_tuser, l: m_tlast, fd: frame_done, es: err_short,
                                el: err_long, esof: err_sof, byp: filter_bypass};
                        if (chk_pulses) begin
                            check("beat", act, e);
                            check("latency_cycle", cyc, ec);
                        end else begin
                            check("beat_data", {m_tdata, m_tuser, m_tlast}, {e.d, e.u, e.l});
                        end
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_dat   = {m_tdata, m_tuser, m_tlast};
            end
        end
    end

    // Drive one beat and wait until accepted; expected output is queued on acceptance.
    task automatic send(input logic [23:0] d, input logic u, input logic l, input bit fwd, input rec_t e);
        bit ok;
        ok = 1'b0;
        last_wait = 0;
        s_tdata = d;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_tready;
            if (!ok) begin
                @(posedge clk);
                #1;
                last_wait++;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: beat %h not accepted within 200 cycles", d);
        end else begin
            @(posedge clk);
            #1;
            if (fwd) begin
                exp_q.push_back(e);
                cyc_q.push_back(cyc);
            end
        end
    endtask

    task automatic beat(input int f, input int ln, input int px, input bit u, input bit l, input bit fwd,
                        input bit fd, input bit es, input bit el, input bit esof, input bit byp);
        rec_t e;
        e = '{d: dat(f, ln, px), u: u, l: l | el, fd: fd, es: es, el: el, esof: esof, byp: byp};
        send(e.d, u, l, fwd, e);
    endtask

    task automatic frame(input int f, input int w, input int h, input bit byp, input int bp_line, input bit first_esof);
        for (int ln = 0; ln < h; ln++) begin
            for (int px = 0; px < w; px++) begin
                if (ln == bp_line && px == 0) cfg_bypass = 1'b1;
                beat(f, ln, px, ln == 0 && px == 0, px == w - 1, 1'b1,
                     ln == h - 1 && px == w - 1, 1'b0, 1'b0, first_esof && ln == 0 && px == 0, byp);
            end
        end
    endtask

    task automatic drain();
        int i;
        s_tvalid = 1'b0;
        for (i = 0; i < 3000 && (exp_q.size() != 0 || m_tvalid); i++) begin
            @(posedge clk);
            #1;
        end
        if (i >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int fd, input int es, input int el, input int esof);
        check({tag, "_frame_done_cnt"}, cnt_fd, fd);
        check({tag, "_err_short_cnt"}, cnt_es, es);
        check({tag, "_err_long_cnt"}, cnt_el, el);
        check({tag, "_err_sof_cnt"}, cnt_esof, esof);
        cnt_fd = 0;
        cnt_es = 0;
        cnt_el = 0;
        cnt_esof = 0;
    endtask

    // Holds reset with a live SOF on the input; everything must read zero.
    task automatic reset_and_check(input string tag);
        reset = 1'b0;
        s_tvalid = 1'b1;
        s_tuser = 1'b1;
        s_tlast = 1'b1;
        s_tdata = 24'hABCDEF;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tuser_tlast"}, {m_tuser, m_tlast}, 0);
        check({tag, "_filter_bypass"}, filter_bypass, 0);
        check({tag, "_pulses"}, {frame_done, err_short, err_long, err_sof}, 0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        cfg_width = 12'd20;
        cfg_height = 12'd10;
        cfg_bypass = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset_and_check("reset");

        // Clean 20x10 frame.
        frame(1, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("clean", 1, 0, 0, 0);

        // Leading garbage is consumed without stalling, then a clean frame.
        for (int i = 0; i < 5; i++) begin
            beat(99, 9, i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("garbage_no_stall", last_wait, 0);
        end
        frame(2, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("garbage", 1, 0, 0, 0);

        // Short line: line 3 ends at px 14.
        for (int ln = 0; ln < 3; ln++)
            for (int px = 0; px < 20; px++)
                beat(3, ln, px, ln == 0 && px == 0, px == 19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int px = 0; px < 15; px++)
            beat(3, 3, px, 1'b0, px == 14, 1'b1, 1'b0, px == 14, 1'b0, 1'b0, 1'b0);
        for (int px = 0; px < 20; px++)
            beat(3, 4, px, 1'b0, px == 19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(4, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("short", 1, 1, 0, 0);

        // Long line: line 0 has no tlast at px 19; tlast finally at px 24.
        for (int px = 0; px < 20; px++)
            beat(5, 0, px, px == 0, 1'b0, 1'b1, 1'b0, 1'b0, px == 19, 1'b0, 1'b0);
        for (int px = 20; px < 25; px++)
            beat(5, 0, px, 1'b0, px == 24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int px = 0; px < 20; px++)
            beat(5, 1, px, 1'b0, px == 19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(6, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("long", 1, 0, 1, 0);

        // Bypass requested mid-frame applies from the next SOF only.
        frame(7, 20, 10, 1'b0, 5, 1'b0);
        frame(8, 20, 10, 1'b1, -1, 1'b0);
        cfg_bypass = 1'b0;
        frame(9, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("bypass", 3, 0, 0, 0);

        // SOF in the middle of line 2 restarts the frame.
        for (int ln = 0; ln < 2; ln++)
            for (int px = 0; px < 20; px++)
                beat(10, ln, px, ln == 0 && px == 0, px == 19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int px = 0; px < 5; px++)
            beat(10, 2, px, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(11, 20, 10, 1'b0, -1, 1'b1);
        drain();
        check_counts("mid_sof", 1, 0, 0, 1);

        // W=1: every beat ends a line, SOF carries tlast.
        cfg_width = 12'd1;
        cfg_height = 12'd3;
        frame(12, 1, 3, 1'b0, -1, 1'b0);
        drain();
        check_counts("w1", 1, 0, 0, 0);

        // Zero geometry behaves as 1x1.
        cfg_width = 12'd0;
        cfg_height = 12'd0;
        frame(13, 1, 1, 1'b0, -1, 1'b0);
        drain();
        check_counts("w0h0", 1, 0, 0, 0);

        // Random output backpressure: same sequence, no loss.
        cfg_width = 12'd20;
        cfg_height = 12'd10;
        chk_pulses = 1'b0;
        bp_en = 1'b1;
        frame(14, 20, 10, 1'b0, -1, 1'b0);
        bp_en = 1'b0;
        drain();
        chk_pulses = 1'b1;
        check_counts("backpressure", 1, 0, 0, 0);

        // Reset during line 4 of a bypassed frame, then resume from a new SOF.
        cfg_bypass = 1'b1;
        for (int ln = 0; ln < 4; ln++)
            for (int px = 0; px < 20; px++)
                beat(15, ln, px, ln == 0 && px == 0, px == 19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int px = 0; px < 10; px++)
            beat(15, 4, px, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        cfg_bypass = 1'b0;
        reset_and_check("midframe_reset");
        for (int px = 10; px < 20; px++)
            beat(15, 4, px, 1'b0, px == 19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(16, 20, 10, 1'b0, -1, 1'b0);
        drain();
        check_counts("after_reset", 1, 0, 0, 0);

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
